// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding,
// program-counter source-select codes and the program address width.
package fetch_ctrl_pkg;

   // Program address width used by the fetch stage.
   localparam int ADDR_W = 14;

   // One-hot program-counter source selects, shared with the fetch-stage mux.
   localparam logic [3:0] SEL_NEXT   = 4'b0001;
   localparam logic [3:0] SEL_BRANCH = 4'b0010;
   localparam logic [3:0] SEL_INT    = 4'b0100;
   localparam logic [3:0] SEL_RET    = 4'b1000;

   // Sequencer states: normal fetch, pipeline drain before vectoring, vector cycle.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      VECTOR = 2'd2
   } fetch_state_t;

   // Vector slot address: base plus the slot index scaled by the slot size.
   // The result wraps to the program address width.
   function automatic logic [ADDR_W-1:0] vector_addr(
      input logic [ADDR_W-1:0] base,
      input logic [ADDR_W-1:0] idx,
      input int                shift
   );
      return base + (idx << shift);
   endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder for the interrupt request lines.
// The lowest-numbered active request wins.
module irq_priority_encoder #(
   parameter int NUM_IRQ = 8,
   parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = |req;
      index = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer. Chooses the program-counter source each cycle,
// stalls and flushes the front end, and runs interrupt entry: accept,
// drain the older instructions, then vector with acknowledge.
module fetch_sequencer
   import fetch_ctrl_pkg::*;
#(
   parameter int                NUM_IRQ      = 8,
   parameter logic [ADDR_W-1:0] VECTOR_BASE  = 14'h0004,
   parameter int                VECTOR_SHIFT = 2,
   parameter int                DRAIN_CYCLES = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                hazard_stall,
   input  logic                branch_taken,
   input  logic                ret_taken,
   input  logic                reti,
   input  logic                ei,
   input  logic                di,
   input  logic [NUM_IRQ-1:0]  int_req,
   output logic [3:0]          prog_cntr_input_sel,
   output logic                stall,
   output logic                flush,
   output logic [ADDR_W-1:0]   interrupt_branch_addr,
   output logic [NUM_IRQ-1:0]  int_ack,
   output logic                ret_push,
   output logic                int_enable,
   output logic                int_active
);

   localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   fetch_state_t     state;
   fetch_state_t     state_next;
   logic [2:0]       drain_cnt;
   logic [IDX_W-1:0] irq_idx;
   logic             enc_valid;
   logic [IDX_W-1:0] enc_idx;
   logic             redirect;
   logic             accept;
   logic             reti_done;

   irq_priority_encoder #(
      .NUM_IRQ (NUM_IRQ),
      .IDX_W   (IDX_W)
   ) u_prio (
      .req   (int_req),
      .valid (enc_valid),
      .index (enc_idx)
   );

   // Redirects from execute always beat interrupt acceptance; a return only
   // restores interrupt state when it is not overridden by a vector cycle.
   assign redirect  = branch_taken | ret_taken;
   assign accept    = (state == RUN) && !redirect && int_enable && enc_valid;
   assign reti_done = (state != VECTOR) && ret_taken && reti;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept enters drain, redirects abandon drain, and the
   // vector cycle always lasts exactly one cycle.
   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (accept) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (redirect) begin
               state_next = RUN;
            end else if (!hazard_stall && (drain_cnt <= 3'd1)) begin
               state_next = VECTOR;
            end
         end
         VECTOR: begin
            state_next = RUN;
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   // Output decode: redirects never stall, drain holds the PC, vector cycle
   // loads the interrupt address and strobes acknowledge and return push.
   always_comb begin
      prog_cntr_input_sel = SEL_NEXT;
      stall               = 1'b0;
      flush               = 1'b0;
      int_ack             = '0;
      ret_push            = 1'b0;
      case (state)
         RUN, DRAIN: begin
            if (ret_taken) begin
               prog_cntr_input_sel = SEL_RET;
               flush               = 1'b1;
            end else if (branch_taken) begin
               prog_cntr_input_sel = SEL_BRANCH;
               flush               = 1'b1;
            end else if ((state == DRAIN) || accept) begin
               stall = 1'b1;
            end else begin
               stall = hazard_stall;
            end
         end
         VECTOR: begin
            prog_cntr_input_sel = SEL_INT;
            flush               = 1'b1;
            int_ack             = NUM_IRQ'(1) << irq_idx;
            ret_push            = 1'b1;
         end
         default: begin
            prog_cntr_input_sel = SEL_NEXT;
         end
      endcase
   end

   // Drain counter: loaded at accept, counts down only on unstalled drain cycles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drain_cnt <= '0;
      end else if (accept) begin
         drain_cnt <= 3'(DRAIN_CYCLES);
      end else if ((state == DRAIN) && !redirect && !hazard_stall && (drain_cnt != 3'd0)) begin
         drain_cnt <= drain_cnt - 3'd1;
      end
   end

   // Capture the winning request and its vector address at accept; both hold
   // until the next accept so the fetch stage sees a stable address.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         irq_idx               <= '0;
         interrupt_branch_addr <= VECTOR_BASE;
      end else if (accept) begin
         irq_idx               <= enc_idx;
         interrupt_branch_addr <= vector_addr(VECTOR_BASE, ADDR_W'(enc_idx), VECTOR_SHIFT);
      end
   end

   // Global interrupt enable and in-service flag. Vector entry wins over
   // everything, disable wins over enable, and reti re-enables on exit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         int_enable <= 1'b0;
         int_active <= 1'b0;
      end else begin
         if (state == VECTOR) begin
            int_enable <= 1'b0;
         end else if (di) begin
            int_enable <= 1'b0;
         end else if (ei || reti_done) begin
            int_enable <= 1'b1;
         end
         if (state == VECTOR) begin
            int_active <= 1'b1;
         end else if (reti_done) begin
            int_active <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer. The stimulus process
// drives one cycle of inputs and queues the hand-computed outputs for that
// cycle; the monitor pops and compares on the falling edge.
module tb_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        hazard_stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic        ret_taken = 1'b0;
   logic        reti = 1'b0;
   logic        ei = 1'b0;
   logic        di = 1'b0;
   logic [7:0]  int_req = 8'h00;
   logic [3:0]  prog_cntr_input_sel;
   logic        stall;
   logic        flush;
   logic [13:0] interrupt_branch_addr;
   logic [7:0]  int_ack;
   logic        ret_push;
   logic        int_enable;
   logic        int_active;

   typedef struct {
      logic [3:0]  sel;
      logic        stall;
      logic        flush;
      logic [7:0]  ack;
      logic        push;
      logic        ie;
      logic        act;
      logic [13:0] addr;
      int          step;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;
   int   stepNum = 0;

   localparam logic [3:0] NX = 4'b0001;
   localparam logic [3:0] BR = 4'b0010;
   localparam logic [3:0] IN = 4'b0100;
   localparam logic [3:0] RT = 4'b1000;

   fetch_sequencer #(
      .NUM_IRQ      (8),
      .VECTOR_BASE  (14'h0004),
      .VECTOR_SHIFT (2),
      .DRAIN_CYCLES (2)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .hazard_stall          (hazard_stall),
      .branch_taken          (branch_taken),
      .ret_taken             (ret_taken),
      .reti                  (reti),
      .ei                    (ei),
      .di                    (di),
      .int_req               (int_req),
      .prog_cntr_input_sel   (prog_cntr_input_sel),
      .stall                 (stall),
      .flush                 (flush),
      .interrupt_branch_addr (interrupt_branch_addr),
      .int_ack               (int_ack),
      .ret_push              (ret_push),
      .int_enable            (int_enable),
      .int_active            (int_active)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Compare one field and log a failure line if it differs.
   task automatic checkOutput(input string name, input int step, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL step%0d %s: got %h expected %h", step, name, got, want);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and queue the outputs expected in that cycle.
   task automatic applyStimulus(
      input logic rst, input logic hs, input logic br, input logic rt, input logic rti,
      input logic e, input logic d, input logic [7:0] irq,
      input logic [3:0] sel, input logic st, input logic fl, input logic [7:0] ack,
      input logic push, input logic ie, input logic act, input logic [13:0] addr
   );
      exp_t ex;
      @(posedge clock);
      #1;
      reset        = rst;
      hazard_stall = hs;
      branch_taken = br;
      ret_taken    = rt;
      reti         = rti;
      ei           = e;
      di           = d;
      int_req      = irq;
      stepNum++;
      ex.sel = sel; ex.stall = st; ex.flush = fl; ex.ack = ack; ex.push = push;
      ex.ie = ie; ex.act = act; ex.addr = addr; ex.step = stepNum;
      expQ.push_back(ex);
   endtask

   // Monitor: pop the queued expectation for this cycle and compare every output.
   always @(negedge clock) begin
      if (expQ.size() > 0) begin
         exp_t ex;
         ex = expQ.pop_front();
         checkOutput("sel",   ex.step, 32'(prog_cntr_input_sel),   32'(ex.sel));
         checkOutput("stall", ex.step, 32'(stall),                 32'(ex.stall));
         checkOutput("flush", ex.step, 32'(flush),                 32'(ex.flush));
         checkOutput("ack",   ex.step, 32'(int_ack),               32'(ex.ack));
         checkOutput("push",  ex.step, 32'(ret_push),              32'(ex.push));
         checkOutput("ie",    ex.step, 32'(int_enable),            32'(ex.ie));
         checkOutput("act",   ex.step, 32'(int_active),            32'(ex.act));
         checkOutput("addr",  ex.step, 32'(interrupt_branch_addr), 32'(ex.addr));
      end
   end

   // Directed sequence: rst hs br rt rti ei di irq | sel stall flush ack push ie act addr
   initial begin
      $display("[TB] starting fetch_sequencer directed run");
      // reset, then idle with IE=0 so a request is never taken
      applyStimulus(1,0,0,0,0,0,0,8'h00, NX,0,0,8'h00,0,0,0,14'h0004);
      applyStimulus(0,0,0,0,0,0,0,8'h01, NX,0,0,8'h00,0,0,0,14'h0004);
      applyStimulus(0,1,0,0,0,0,0,8'h01, NX,1,0,8'h00,0,0,0,14'h0004);
      // branch beats hazard stall; ret beats branch
      applyStimulus(0,1,1,0,0,0,0,8'h00, BR,0,1,8'h00,0,0,0,14'h0004);
      applyStimulus(0,0,1,1,0,0,0,8'h00, RT,0,1,8'h00,0,0,0,14'h0004);
      // enable interrupts, accept 8'h28 (index 3) and enter
      applyStimulus(0,0,0,0,0,1,0,8'h00, NX,0,0,8'h00,0,0,0,14'h0004);
      applyStimulus(0,0,0,0,0,0,0,8'h28, NX,1,0,8'h00,0,1,0,14'h0004);
      applyStimulus(0,0,0,0,0,0,0,8'h00, NX,1,0,8'h00,0,1,0,14'h0010);
      applyStimulus(0,0,0,0,0,0,0,8'h00, NX,1,0,8'h00,0,1,0,14'h0010);
      applyStimulus(0,0,0,0,0,0,0,8'h00, IN,0,1,8'h08,1,1,0,14'h0010);
      applyStimulus(0,0,0,0,0,0,0,8'h00, NX,0,0,8'h00,0,0,1,14'h0010);
      // reti re-enables and leaves the ISR
      applyStimulus(0,0,0,1,1,0,0,8'h00, RT,0,1,8'h00,0,0,1,14'h0010);
      // accept, abort drain with a branch, re-accept next cycle
      applyStimulus(0,0,0,0,0,0,0,8'h28, NX,1,0,8'h00,0,1,0,14'h0010);
      applyStimulus(0,0,1,0,0,0,0,8'h28, BR,0,1,8'h00,0,1,0,14'h0010);
      applyStimulus(0,0,0,0,0,0,0,8'h28, NX,1,0,8'h00,0,1,0,14'h0010);
      // three stalled drain cycles push the vector cycle out by three
      applyStimulus(0,1,0,0,0,0,0,8'h00, NX,1,0,8'h00,0,1,0,14'h0010);
      applyStimulus(0,1,0,0,0,0,0,8'h00, NX,1,0,8'h00,0,1,0,14'h0010);
      applyStimulus(0,1,0,0,0,0,0,8'h00, NX,1,0,8'h00,0,1,0,14'h0010);
      applyStimulus(0,0,0,0,0,0,0,8'h00, NX,1,0,8'h00,0,1,0,14'h0010);
      applyStimulus(0,0,0,0,0,0,0,8'h00, NX,1,0,8'h00,0,1,0,14'h0010);
      applyStimulus(0,0,0,0,0,0,0,8'h00, IN,0,1,8'h08,1,1,0,14'h0010);
      // reti, accept 8'h06 (index 1), then reset during drain
      applyStimulus(0,0,0,1,1,0,0,8'h00, RT,0,1,8'h00,0,0,1,14'h0010);
      applyStimulus(0,0,0,0,0,0,0,8'h06, NX,1,0,8'h00,0,1,0,14'h0010);
      applyStimulus(1,0,0,0,0,0,0,8'h06, NX,0,0,8'h00,0,0,0,14'h0004);
      applyStimulus(0,0,0,0,0,0,0,8'h06, NX,0,0,8'h00,0,0,0,14'h0004);
      applyStimulus(0,0,0,0,0,0,0,8'h06, NX,0,0,8'h00,0,0,0,14'h0004);
      // ei with di: di wins, request stays blocked
      applyStimulus(0,0,0,0,0,1,1,8'h00, NX,0,0,8'h00,0,0,0,14'h0004);
      applyStimulus(0,0,0,0,0,0,0,8'h01, NX,0,0,8'h00,0,0,0,14'h0004);
      // top request line: index 7 gives 0x0020; ei during vector is overridden
      applyStimulus(0,0,0,0,0,1,0,8'h00, NX,0,0,8'h00,0,0,0,14'h0004);
      applyStimulus(0,0,0,0,0,0,0,8'h80, NX,1,0,8'h00,0,1,0,14'h0004);
      applyStimulus(0,0,0,0,0,0,0,8'h00, NX,1,0,8'h00,0,1,0,14'h0020);
      applyStimulus(0,0,0,0,0,0,0,8'h00, NX,1,0,8'h00,0,1,0,14'h0020);
      applyStimulus(0,0,0,0,0,1,0,8'h00, IN,0,1,8'h80,1,1,0,14'h0020);
      applyStimulus(0,0,0,0,0,0,0,8'h00, NX,0,0,8'h00,0,0,1,14'h0020);
      @(posedge clock);
      @(posedge clock);
      checkOutput("queue_drained", stepNum, 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences the fetch stage: each cycle it decides the program-counter load source, the fetch stall and the front-end flush. It arbitrates between four requests: sequential fetch, execute-resolved branch redirect, return redirect and interrupt entry. It also owns global interrupt enable, interrupt priority, the vector address and the interrupt-entry drain sequence. It sits beside the hazard logic and drives the fetch stage's source-select, stall and interrupt-branch-address inputs.

## Interface
Parameters:
- NUM_IRQ, 8, number of level-sensitive interrupt request lines (1..16)
- VECTOR_BASE, 14'h0004, program address of vector 0
- VECTOR_SHIFT, 2, log2 of words per vector slot
- DRAIN_CYCLES, 2, bubble cycles inserted before vectoring (1..7)

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- hazard_stall  in  1  load-use / memory stall request
- branch_taken  in  1  execute resolved a taken branch/jump this cycle
- ret_taken  in  1  execute resolved ret/reti this cycle
- reti  in  1  qualifies ret_taken as return-from-interrupt
- ei, di  in  1 each  enable / disable-interrupt instruction retired
- int_req  in  NUM_IRQ  level interrupt requests
- prog_cntr_input_sel  out  4  one-hot: [0] next, [1] branch, [2] interrupt, [3] return
- stall  out  1  hold program counter
- flush  out  1  squash IF/ID and ID/EX
- interrupt_branch_addr  out  14  vector address of accepted IRQ
- int_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge
- ret_push  out  1  one-cycle strobe: return stack captures resume PC
- int_enable  out  1  global interrupt enable (IE)
- int_active  out  1  ISR in progress

## Operation
- FSM states: RUN, DRAIN, VECTOR.
- RUN, priority high→low:
  - ret_taken: sel=1000, flush=1. If reti, IE←1 and int_active←0 at the edge.
  - branch_taken: sel=0010, flush=1.
  - IRQ accept: condition is IE & |int_req & !ctrl redirect. Latch the lowest-index set bit as `irq_idx`, load the drain counter with DRAIN_CYCLES, go to DRAIN. In this cycle sel=0001 and stall=1.
  - hazard_stall: sel=0001, stall=1.
  - Otherwise: sel=0001, stall=0, flush=0.
- ret_taken and branch_taken both high: ret wins.
- Any redirect forces stall=0, even when hazard_stall=1.
- DRAIN:
  - Outputs: stall=1, sel=0001, flush=0. The IF/ID register receives bubbles from the stalled fetch, so older instructions retire.
  - The counter decrements only when hazard_stall=0. At 0, go to VECTOR.
  - branch_taken/ret_taken in DRAIN: perform the redirect as in RUN, abandon the entry and return to RUN. The IRQ is re-evaluated next cycle because it is level-sensitive; no ack is issued.
- VECTOR, exactly one cycle, then RUN:
  - sel=0100, flush=1, int_ack=1<<irq_idx, ret_push=1.
  - At the edge: IE←0, int_active←1.
- interrupt_branch_addr = VECTOR_BASE + (irq_idx << VECTOR_SHIFT), truncated to 14 bits, registered at accept. It holds its value otherwise.
- IE updates:
  - ei sets IE; di clears it; ei and di together: di wins.
  - VECTOR entry clearing IE overrides ei.
- IE=0 blocks acceptance, so there is no nesting.
- Reset mid-sequence: state returns to RUN immediately and every output takes its reset value. An in-progress entry is discarded and no ack is issued.

## Timing
- Reset values:
  - state RUN, sel=0001, stall=0, flush=0, int_ack=0, ret_push=0
  - IE=0, int_active=0, interrupt_branch_addr=VECTOR_BASE
- sel, stall and flush are combinational from state and the current-cycle inputs. Redirects take effect at the same edge that execute resolves.
- IRQ accepted in cycle T (no hazard stalls):
  - DRAIN occupies T+1..T+DRAIN_CYCLES.
  - VECTOR is in T+DRAIN_CYCLES+1.
  - The first ISR fetch address appears at T+DRAIN_CYCLES+2.
- int_ack and ret_push are high for exactly the VECTOR cycle.
- Any asserted int_req, including a request lasting a single cycle, is accepted only if it is high in an accept-eligible RUN cycle. There is no edge capture.

## Structure
- Package fetch_ctrl_pkg holds:
  - the state encoding (RUN, DRAIN, VECTOR)
  - the SEL_NEXT/SEL_BRANCH/SEL_INT/SEL_RET one-hot constants shared with the fetch stage's source mux
  - the 14-bit address width constant
- One sub-module, irq_priority_encoder: input NUM_IRQ, outputs valid and index; lowest index wins. The rest is a single FSM module.

## Test plan
- Reset then idle:
  - Stimulus: reset pulse, no requests.
  - Required: sel=0001, stall=0, IE=0; int_req=8'h01 is never acked.
- Branch plus stall:
  - Stimulus: branch_taken=1 with hazard_stall=1.
  - Required: sel=0010, flush=1, stall=0. Then branch_taken and ret_taken together give sel=1000.
- Interrupt entry:
  - Stimulus: ei; then int_req=8'h28 at T.
  - Required: DRAIN over T+1..T+2; VECTOR at T+3 with int_ack=8'h08, ret_push=1, sel=0100; interrupt_branch_addr=14'h0010. IE=0 and int_active=1 from T+4.
- Drain abort and retry:
  - Stimulus: branch_taken during DRAIN.
  - Required: sel=0010, no ack, back to RUN. With int_req held, re-accept on the next cycle.
- Stall extends drain:
  - Stimulus: hazard_stall held for 3 cycles during DRAIN.
  - Required: VECTOR is delayed by exactly 3 cycles.
- Return from interrupt, then reset mid-entry:
  - Stimulus: ret_taken with reti.
  - Required: sel=1000, IE=1, int_active=0.
  - Stimulus: reset asserted in DRAIN.
  - Required: all outputs return to reset values the same cycle.
